// File: rtl/debug_module_pkg.sv
// Shared types for the sysid reader: FSM state encoding, sysid word addresses, data word.
package debug_module_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ID_REQ,
        ST_ID_WAIT,
        ST_TS_REQ,
        ST_TS_WAIT,
        ST_DONE
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/debug_module_sysid_reader.sv
// Reads the sysid slave over Avalon-MM after reset (or on start) and compares it against the
// expected ID/timestamp. Define SYSID_READER_TIMESTAMP_EN to also read and check the timestamp.
module debug_module_sysid_reader
    import debug_module_pkg::*;
#(
    parameter word_t       EXPECTED_ID    = 32'd0,
    parameter word_t       EXPECTED_TS    = 32'd1672759086,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic  clock,
    input  logic  reset_n,
    input  logic  start,
    output logic  avm_address,
    output logic  avm_read,
    input  logic  avm_waitrequest,
    input  logic  avm_readdatavalid,
    input  word_t avm_readdata,
    output word_t id_value,
    output word_t ts_value,
    output logic  done,
    output logic  match,
    output logic  timeout_err
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
`ifdef SYSID_READER_TIMESTAMP_EN
    localparam state_t AFTER_ID = ST_TS_REQ;
`else
    localparam state_t AFTER_ID = ST_DONE;
`endif

    state_t     state, state_next;
    logic [7:0] cnt;
    word_t      id_next;
    logic       in_xfer, timed_out, accepted, enter_done, leave_done, ts_ok;

`ifdef SYSID_READER_TIMESTAMP_EN
    word_t ts_reg, ts_next;
    assign ts_value = ts_reg;
    assign ts_ok    = (ts_next == EXPECTED_TS);
`else
    logic unused_ts_param;
    assign unused_ts_param = ^EXPECTED_TS;
    assign ts_value        = '0;
    assign ts_ok           = 1'b1;
`endif

    assign avm_read    = (state == ST_ID_REQ) || (state == ST_TS_REQ);
    assign avm_address = (state == ST_TS_REQ) ? SYSID_ADDR_TS : SYSID_ADDR_ID;

    always_comb begin
        state_next = state;
        id_next    = id_value;
`ifdef SYSID_READER_TIMESTAMP_EN
        ts_next    = ts_reg;
`endif
        in_xfer    = (state == ST_ID_REQ) || (state == ST_ID_WAIT) ||
                     (state == ST_TS_REQ) || (state == ST_TS_WAIT);
        timed_out  = in_xfer && (cnt == TIMEOUT_LIMIT);
        accepted   = avm_read && !avm_waitrequest;
        // Timeout wins even if the slave answers in the same cycle.
        if (timed_out) begin
            state_next = ST_DONE;
        end else begin
            case (state)
                ST_IDLE: state_next = ST_ID_REQ;
                ST_ID_REQ: begin
                    if (accepted) begin
                        if (avm_readdatavalid) begin
                            id_next    = avm_readdata;
                            state_next = AFTER_ID;
                        end else begin
                            state_next = ST_ID_WAIT;
                        end
                    end
                end
                ST_ID_WAIT: begin
                    if (avm_readdatavalid) begin
                        id_next    = avm_readdata;
                        state_next = AFTER_ID;
                    end
                end
`ifdef SYSID_READER_TIMESTAMP_EN
                ST_TS_REQ: begin
                    if (accepted) begin
                        if (avm_readdatavalid) begin
                            ts_next    = avm_readdata;
                            state_next = ST_DONE;
                        end else begin
                            state_next = ST_TS_WAIT;
                        end
                    end
                end
                ST_TS_WAIT: begin
                    if (avm_readdatavalid) begin
                        ts_next    = avm_readdata;
                        state_next = ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (start) begin
                        id_next    = '0;
`ifdef SYSID_READER_TIMESTAMP_EN
                        ts_next    = '0;
`endif
                        state_next = ST_ID_REQ;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
        enter_done = (state_next == ST_DONE) && (state != ST_DONE);
        leave_done = (state == ST_DONE) && (state_next != ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            id_value    <= '0;
            done        <= 1'b0;
            match       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_next;
            id_value <= id_next;
            if (state_next != state) begin
                cnt <= '0;
            end else if (in_xfer) begin
                cnt <= cnt + 8'd1;
            end
            // done lags DONE entry by one cycle and drops on the start edge.
            done <= (state == ST_DONE) && (state_next == ST_DONE);
            if (enter_done) begin
                match       <= !timed_out && (id_next == EXPECTED_ID) && ts_ok;
                timeout_err <= timed_out;
            end else if (leave_done) begin
                match       <= 1'b0;
                timeout_err <= 1'b0;
            end
        end
    end

`ifdef SYSID_READER_TIMESTAMP_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_reg <= '0;
        end else begin
            ts_reg <= ts_next;
        end
    end
`endif

endmodule

// File: tb/tb_debug_module_sysid_reader.sv
// Directed bench: a configurable sysid slave, a result model, and a per-cycle compare process.
module tb_debug_module_sysid_reader;

    localparam logic [31:0] EXP_ID  = 32'd0;
    localparam logic [31:0] EXP_TS  = 32'd1672759086;
    localparam int          TIMEOUT = 255;
`ifdef SYSID_READER_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n, start;
    logic        avm_address, avm_read, avm_waitrequest, avm_readdatavalid;
    logic [31:0] avm_readdata, id_value, ts_value;
    logic        done, match, timeout_err;

    debug_module_sysid_reader #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .avm_readdata(avm_readdata), .id_value(id_value), .ts_value(ts_value),
        .done(done), .match(match), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // slave configuration and model expectations
    logic [31:0] mem [2];
    int          cfg_stall = 0, cfg_lat = 0;
    bit          cfg_stuck = 0, cfg_stray = 0;
    logic [31:0] exp_id, exp_ts;
    logic        exp_match, exp_to;
    int          nreads;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic predict();
        exp_to    = cfg_stuck;
        exp_id    = cfg_stuck ? 32'd0 : mem[0];
        exp_ts    = (cfg_stuck || !TS_EN) ? 32'd0 : mem[1];
        exp_match = !cfg_stuck && (mem[0] == EXP_ID) && (!TS_EN || mem[1] == EXP_TS);
        nreads    = cfg_stuck ? 0 : (TS_EN ? 2 : 1);
    endtask

    // Slave: responses for the next rising edge are decided on the falling edge.
    int   stall_left = 0, resp_left = -1;
    bit   req_seen = 0;
    logic resp_addr = 1'b0;
    always @(negedge clock) begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'hDEADBEEF;
        if (!reset_n) begin
            stall_left = 0; resp_left = -1; req_seen = 0;
        end else begin
            if (resp_left > 0) resp_left--;
            if (resp_left == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = mem[resp_addr];
                resp_left         = -1;
            end
            if (avm_read) begin
                if (!req_seen) begin
                    req_seen   = 1;
                    stall_left = cfg_stall;
                end
                if (cfg_stuck || stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    if (stall_left > 0) stall_left--;
                end else begin
                    req_seen = 0;
                    if (cfg_lat == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = mem[avm_address];
                    end else begin
                        resp_left = cfg_lat;
                        resp_addr = avm_address;
                    end
                end
            end else begin
                req_seen = 0;
            end
            if (done && cfg_stray && !avm_readdatavalid) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = 32'hBAD0BAD0;
            end
        end
    end

    // bus monitor
    int   acc_total = 0, rd_total = 0;
    logic prev_stall = 1'b0, prev_addr = 1'b0;
    always @(posedge clock) begin
        prev_stall <= reset_n && avm_read && avm_waitrequest;
        prev_addr  <= avm_address;
        if (reset_n && avm_read && !avm_waitrequest) acc_total <= acc_total + 1;
        if (reset_n && avm_read) rd_total <= rd_total + 1;
    end

    // per-cycle compare against the model
    always @(posedge clock) begin
        #2;
        if (!reset_n) begin
            chk("rst_done", done, 0);
            chk("rst_match", match, 0);
            chk("rst_timeout", timeout_err, 0);
            chk("rst_id", id_value, 0);
            chk("rst_ts", ts_value, 0);
            chk("rst_read", avm_read, 0);
            chk("rst_addr", avm_address, 0);
        end else begin
            if (done) begin
                chk("done_id", id_value, exp_id);
                chk("done_ts", ts_value, exp_ts);
                chk("done_match", match, exp_match);
                chk("done_timeout", timeout_err, exp_to);
                chk("done_read", avm_read, 0);
            end
            if (prev_stall && !cfg_stuck) begin
                chk("stall_read", avm_read, 1);
                chk("stall_addr", avm_address, prev_addr);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < bound) begin
            @(negedge clock);
            cycles++;
        end
        chk(name, done, 1);
    endtask

    initial begin
        int cyc, n, base_acc, base_rd;
        reset_n = 1'b0;
        start   = 1'b0;
        mem[0]  = 32'd0;
        mem[1]  = 32'd1672759086;
        predict();
        repeat (3) @(negedge clock);

        // S1: zero-latency slave, automatic run after reset release
        base_acc = acc_total;
        reset_n  = 1'b1;
        wait_done("s1_done", 20, cyc);
        chk("s1_latency_le6", cyc <= 6, 1);
        chk("s1_id", id_value, 32'd0);
        chk("s1_ts", ts_value, TS_EN ? 32'd1672759086 : 32'd0);
        chk("s1_match", match, 1);
        chk("s1_timeout", timeout_err, 0);
        chk("s1_reads", acc_total - base_acc, nreads);

        // S2: start in DONE clears outputs; 3-cycle stall, 2-cycle read latency
        cfg_stall = 3; cfg_lat = 2;
        predict();
        base_acc = acc_total;
        pulse_start();
        chk("s2_clr_done", done, 0);
        chk("s2_clr_match", match, 0);
        chk("s2_clr_ts", ts_value, 0);
        wait_done("s2_done", 40, cyc);
        chk("s2_match", match, 1);
        chk("s2_reads", acc_total - base_acc, nreads);

        // S3: wrong ID
        cfg_stall = 1; cfg_lat = 1; mem[0] = 32'd5;
        predict();
        pulse_start();
        wait_done("s3_done", 30, cyc);
        chk("s3_id", id_value, 32'd5);
        chk("s3_match", match, 0);

        // S4: timestamp one too high
        cfg_stall = 0; cfg_lat = 0; mem[0] = 32'd0; mem[1] = 32'd1672759087;
        predict();
        pulse_start();
        chk("s4_clr_id", id_value, 0);
        wait_done("s4_done", 20, cyc);
        chk("s4_match", match, TS_EN ? 32'd0 : 32'd1);
        chk("s4_timeout", timeout_err, 0);

        // S5: start mid-sequence is ignored; stray readdatavalid in DONE is ignored
        mem[1] = 32'd1672759086; cfg_lat = 6; cfg_stray = 1;
        predict();
        base_acc = acc_total;
        pulse_start();
        n = 0;
        while (!((acc_total - base_acc) == 1 && !avm_read) && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("s5_in_wait", (acc_total - base_acc) == 1 && !avm_read, 1);
        pulse_start();
        wait_done("s5_done", 40, cyc);
        chk("s5_reads", acc_total - base_acc, nreads);
        repeat (3) @(negedge clock);
        chk("s5_stray_id", id_value, 32'd0);

        // S6: reset during the final wait state, then automatic rerun
        cfg_lat = 5;
        predict();
        base_acc = acc_total;
        pulse_start();
        n = 0;
        while (!((acc_total - base_acc) == nreads && !avm_read && !done) && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("s6_in_wait", (acc_total - base_acc) == nreads && !avm_read && !done, 1);
        reset_n = 1'b0;
        #1;
        chk("s6_rst_done", done, 0);
        chk("s6_rst_read", avm_read, 0);
        chk("s6_rst_ts", ts_value, 0);
        chk("s6_rst_match", match, 0);
        repeat (2) @(negedge clock);
        base_acc = acc_total;
        reset_n  = 1'b1;
        wait_done("s6_done", 40, cyc);
        chk("s6_match", match, 1);
        chk("s6_reads", acc_total - base_acc, nreads);

        // S7: waitrequest stuck high -> timeout after TIMEOUT+1 request cycles (count 0..TIMEOUT)
        cfg_stuck = 1;
        predict();
        base_rd = rd_total;
        pulse_start();
        wait_done("s7_done", 400, cyc);
        chk("s7_read_cycles", rd_total - base_rd, TIMEOUT + 1);
        chk("s7_timeout", timeout_err, 1);
        chk("s7_match", match, 0);

        // S8: recovery after timeout
        cfg_stuck = 0; cfg_stall = 1; cfg_lat = 0;
        predict();
        pulse_start();
        chk("s8_clr_timeout", timeout_err, 0);
        wait_done("s8_done", 30, cyc);
        chk("s8_match", match, 1);

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
